// File: rtl/nfc_arb_pkg.sv
// nfc_arb_pkg: shared state type, requester ids and constants for the NFC command arbiter
package nfc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } arb_state_t;

    localparam logic       REQ_DET       = 1'b0;
    localparam logic       REQ_AUTH      = 1'b1;
    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    // With both eligible the favoured requester wins, otherwise whichever is eligible
    function automatic logic rr_pick(input logic elig0, input logic elig1, input logic favour);
        return (elig0 && elig1) ? favour : elig1;
    endfunction

endpackage

// File: rtl/nfc_arb_watchdog.sv
// nfc_arb_watchdog: down-counter that reloads on load and flags expiry when it reaches zero while running
module nfc_arb_watchdog #(
    parameter logic [31:0] LOAD = 32'd1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    logic [31:0] r_cnt;

    // Reload on entry to the guarded wait, count down while it lasts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= LOAD;
        else if (i_run && r_cnt != 32'd0)
            r_cnt <= r_cnt - 32'd1;
    end

    assign o_expired = i_run && (r_cnt == 32'd0);

endmodule

// File: rtl/nfc_cmd_arbiter.sv
// nfc_cmd_arbiter: registered round-robin arbiter sharing the MFRC522 register port between detector and auth.
// Define NFC_ARB_TIMEOUT_EN to abort a command that waits longer than TIMEOUT_CYCLES for completion.
module nfc_cmd_arbiter
    import nfc_arb_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_cmd_valid,
    output logic       r0_cmd_ready,
    input  logic       r0_cmd_write,
    input  logic [5:0] r0_cmd_addr,
    input  logic [7:0] r0_cmd_wdata,
    output logic [7:0] r0_cmd_rdata,
    output logic       r0_cmd_done,
    input  logic       r1_cmd_valid,
    output logic       r1_cmd_ready,
    input  logic       r1_cmd_write,
    input  logic [5:0] r1_cmd_addr,
    input  logic [7:0] r1_cmd_wdata,
    output logic [7:0] r1_cmd_rdata,
    output logic       r1_cmd_done,
    input  logic       r1_lock,
    output logic       nfc_cmd_valid,
    output logic       nfc_cmd_write,
    output logic [5:0] nfc_cmd_addr,
    output logic [7:0] nfc_cmd_wdata,
    input  logic       nfc_cmd_ready,
    input  logic [7:0] nfc_cmd_rdata,
    input  logic       nfc_cmd_done,
    output logic       grant_id,
    output logic       arb_busy,
    output logic       timeout_err
);

    arb_state_t r_state, w_next;
    logic       r_rr;
    logic       r_grant;
    logic       r_write;
    logic [5:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata0;
    logic [7:0] r_rdata1;
    logic       w_elig0;
    logic       w_elig1;
    logic       w_pick;
    logic       w_accept;
    logic       w_expired;
    logic       w_finish;
    logic [7:0] w_resp_data;

    // State register; reset aborts any in-flight command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Eligibility, round-robin selection and next state
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_elig0  = r0_cmd_valid && !r1_lock;
        w_elig1  = r1_cmd_valid;
        w_pick   = rr_pick(w_elig0, w_elig1, r_rr);
        case (r_state)
            IDLE: begin
                if (w_elig0 || w_elig1) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                end
            end
            ISSUE:     w_next = nfc_cmd_ready ? WAIT_DONE : ISSUE;
            WAIT_DONE: w_next = (nfc_cmd_done || w_expired) ? RESP : WAIT_DONE;
            default:   w_next = IDLE;
        endcase
    end

    assign w_finish    = (r_state == WAIT_DONE) && (nfc_cmd_done || w_expired);
    assign w_resp_data = nfc_cmd_done ? nfc_cmd_rdata : TIMEOUT_RDATA;

    // Capture the winner's fields and move the pointer away from it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr    <= REQ_DET;
            r_grant <= REQ_DET;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_rr    <= !w_pick;
            r_grant <= w_pick;
            r_write <= w_pick ? r1_cmd_write : r0_cmd_write;
            r_addr  <= w_pick ? r1_cmd_addr  : r0_cmd_addr;
            r_wdata <= w_pick ? r1_cmd_wdata : r0_cmd_wdata;
        end
    end

    // Response data goes only to the owner and is held until its next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_finish && r_grant == REQ_AUTH) begin
            r_rdata1 <= w_resp_data;
        end else if (w_finish) begin
            r_rdata0 <= w_resp_data;
        end
    end

`ifdef NFC_ARB_TIMEOUT_EN
    logic r_timeout;

    nfc_arb_watchdog #(
        .LOAD(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (r_state == ISSUE && nfc_cmd_ready),
        .i_run    (r_state == WAIT_DONE),
        .o_expired(w_expired)
    );

    // Remember whether the response being delivered is an abort; a real done on the last cycle wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_timeout <= 1'b0;
        else if (w_finish)
            r_timeout <= !nfc_cmd_done;
    end

    assign timeout_err = (r_state == RESP) && r_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_expired        = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    assign r0_cmd_ready  = w_accept && (w_pick == REQ_DET);
    assign r1_cmd_ready  = w_accept && (w_pick == REQ_AUTH);
    assign r0_cmd_done   = (r_state == RESP) && (r_grant == REQ_DET);
    assign r1_cmd_done   = (r_state == RESP) && (r_grant == REQ_AUTH);
    assign r0_cmd_rdata  = r_rdata0;
    assign r1_cmd_rdata  = r_rdata1;
    assign nfc_cmd_valid = (r_state == ISSUE);
    assign nfc_cmd_write = r_write;
    assign nfc_cmd_addr  = r_addr;
    assign nfc_cmd_wdata = r_wdata;
    assign grant_id      = r_grant;
    assign arb_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_nfc_cmd_arbiter.sv
// tb_nfc_cmd_arbiter: directed and randomized checks of nfc_cmd_arbiter against a transaction-level model
module tb_nfc_cmd_arbiter;

    localparam int TO = 16;
`ifdef NFC_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0_cmd_valid, r0_cmd_ready, r0_cmd_write, r0_cmd_done;
    logic [5:0] r0_cmd_addr;
    logic [7:0] r0_cmd_wdata, r0_cmd_rdata;
    logic       r1_cmd_valid, r1_cmd_ready, r1_cmd_write, r1_cmd_done;
    logic [5:0] r1_cmd_addr;
    logic [7:0] r1_cmd_wdata, r1_cmd_rdata;
    logic       r1_lock;
    logic       nfc_cmd_valid, nfc_cmd_write, nfc_cmd_ready, nfc_cmd_done;
    logic [5:0] nfc_cmd_addr;
    logic [7:0] nfc_cmd_wdata, nfc_cmd_rdata;
    logic       grant_id, arb_busy, timeout_err;

    logic       q_v[2];
    logic       q_w[2];
    logic [5:0] q_a[2];
    logic [7:0] q_d[2];
    int         req_cnt[2];
    bit         acc[2];
    bit         fix[2];
    bit         fw[2];
    logic [5:0] fa[2];
    logic [7:0] fd[2];
    bit         dev_auto;
    int         gq[$];
    int         total = 0;
    int         bad = 0;

    bit         m_busy, m_sent, m_ret, m_to, m_owner, m_last, m_gid, m_w;
    bit [5:0]   m_a;
    bit [7:0]   m_d;
    bit [7:0]   m_rd[2];
    int         m_cnt;
    bit         e0, e1, any_req, pk;

    assign r0_cmd_valid = q_v[0];
    assign r0_cmd_write = q_w[0];
    assign r0_cmd_addr  = q_a[0];
    assign r0_cmd_wdata = q_d[0];
    assign r1_cmd_valid = q_v[1];
    assign r1_cmd_write = q_w[1];
    assign r1_cmd_addr  = q_a[1];
    assign r1_cmd_wdata = q_d[1];

    nfc_cmd_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_cmd_valid(r0_cmd_valid), .r0_cmd_ready(r0_cmd_ready), .r0_cmd_write(r0_cmd_write),
        .r0_cmd_addr(r0_cmd_addr), .r0_cmd_wdata(r0_cmd_wdata), .r0_cmd_rdata(r0_cmd_rdata),
        .r0_cmd_done(r0_cmd_done),
        .r1_cmd_valid(r1_cmd_valid), .r1_cmd_ready(r1_cmd_ready), .r1_cmd_write(r1_cmd_write),
        .r1_cmd_addr(r1_cmd_addr), .r1_cmd_wdata(r1_cmd_wdata), .r1_cmd_rdata(r1_cmd_rdata),
        .r1_cmd_done(r1_cmd_done), .r1_lock(r1_lock),
        .nfc_cmd_valid(nfc_cmd_valid), .nfc_cmd_write(nfc_cmd_write), .nfc_cmd_addr(nfc_cmd_addr),
        .nfc_cmd_wdata(nfc_cmd_wdata), .nfc_cmd_ready(nfc_cmd_ready), .nfc_cmd_rdata(nfc_cmd_rdata),
        .nfc_cmd_done(nfc_cmd_done), .grant_id(grant_id), .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            0: return r0_cmd_ready;
            1: return r1_cmd_ready;
            2: return r0_cmd_done;
            default: return r1_cmd_done;
        endcase
    endfunction

    task automatic wait_sig(input int s, input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sig(s) && k < 300);
        chk(nm, sig(s), 1);
    endtask

    task automatic wait_gq(input int n, input string nm);
        int k = 0;
        while (gq.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk(nm, gq.size() >= n, 1);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((req_cnt[0] != 0 || req_cnt[1] != 0 || q_v[0] || q_v[1] || arb_busy) && k < 3000);
        chk(nm, arb_busy, 0);
    endtask

    task automatic clear_reqs();
        req_cnt[0] = 0; req_cnt[1] = 0;
        q_v[0] = 1'b0;  q_v[1] = 1'b0;
        acc[0] = 1'b0;  acc[1] = 1'b0;
        fix[0] = 1'b0;  fix[1] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        clear_reqs();
        r1_lock = 1'b0;
        nfc_cmd_ready = 1'b0;
        nfc_cmd_done = 1'b0;
        gq.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    function automatic int gqa(input int i);
        return (gq.size() > i) ? gq[i] : -1;
    endfunction

    // Transaction model: a command is accepted, sent downstream, answered (or aborted), then reported
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_sent = 0; m_ret = 0; m_to = 0; m_owner = 0;
            m_last = 1; m_gid = 0; m_w = 0; m_a = 0; m_d = 0;
            m_rd[0] = 8'h00; m_rd[1] = 8'h00; m_cnt = 0;
        end else begin
            e0 = q_v[0] && !r1_lock;
            e1 = q_v[1];
            any_req = e0 || e1;
            pk = (e0 && e1) ? !m_last : e1;
            chk("ready0", r0_cmd_ready, !m_busy && any_req && !pk);
            chk("ready1", r1_cmd_ready, !m_busy && any_req && pk);
            chk("nfc_valid", nfc_cmd_valid, m_busy && !m_sent);
            chk("nfc_write", nfc_cmd_write, m_w);
            chk("nfc_addr", nfc_cmd_addr, m_a);
            chk("nfc_wdata", nfc_cmd_wdata, m_d);
            chk("done0", r0_cmd_done, m_busy && m_ret && !m_owner);
            chk("done1", r1_cmd_done, m_busy && m_ret && m_owner);
            chk("rdata0", r0_cmd_rdata, m_rd[0]);
            chk("rdata1", r1_cmd_rdata, m_rd[1]);
            chk("grant_id", grant_id, m_gid);
            chk("arb_busy", arb_busy, m_busy);
            chk("timeout_err", timeout_err, m_busy && m_ret && m_to);
            if (r0_cmd_ready) begin acc[0] = 1; gq.push_back(0); end
            if (r1_cmd_ready) begin acc[1] = 1; gq.push_back(1); end
            if (!m_busy) begin
                if (any_req) begin
                    m_busy = 1; m_sent = 0; m_ret = 0; m_to = 0;
                    m_owner = pk; m_gid = pk; m_last = pk;
                    m_w = q_w[pk]; m_a = q_a[pk]; m_d = q_d[pk];
                end
            end else if (!m_sent) begin
                if (nfc_cmd_ready) begin m_sent = 1; m_cnt = TO; end
            end else if (!m_ret) begin
                if (nfc_cmd_done) begin
                    m_ret = 1; m_rd[m_owner] = nfc_cmd_rdata;
                end else if (TO_EN) begin
                    if (m_cnt == 0) begin m_ret = 1; m_to = 1; m_rd[m_owner] = 8'hFF; end
                    else m_cnt--;
                end
            end else begin
                m_busy = 0;
            end
        end
    end

    // Requesters: issue req_cnt commands each, holding valid and fields until accepted
    initial forever begin
        @(posedge clk); #1;
        for (int n = 0; n < 2; n++) begin
            if (acc[n]) begin
                acc[n] = 0;
                if (req_cnt[n] > 0) req_cnt[n]--;
                q_v[n] = 1'b0;
            end
            if (req_cnt[n] > 0 && !q_v[n]) begin
                q_v[n] = 1'b1;
                q_w[n] = fix[n] ? fw[n] : 1'($urandom_range(0, 1));
                q_a[n] = fix[n] ? fa[n] : 6'($urandom);
                q_d[n] = fix[n] ? fd[n] : 8'($urandom);
            end else if (req_cnt[n] == 0) begin
                q_v[n] = 1'b0;
            end
        end
    end

    // Downstream reader: random ready, random (sometimes spurious) done and data
    initial forever begin
        @(posedge clk); #1;
        if (dev_auto) begin
            nfc_cmd_ready = 1'($urandom_range(0, 1));
            nfc_cmd_done  = ($urandom_range(0, 3) == 0);
            nfc_cmd_rdata = 8'($urandom);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        q_w[0] = 0; q_w[1] = 0; q_a[0] = 0; q_a[1] = 0; q_d[0] = 0; q_d[1] = 0;
        fw[0] = 0; fw[1] = 0; fa[0] = 0; fa[1] = 0; fd[0] = 0; fd[1] = 0;
        clear_reqs();
        r1_lock = 0; dev_auto = 0;
        nfc_cmd_ready = 0; nfc_cmd_done = 0; nfc_cmd_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", arb_busy, 0);
        chk("rst_nfc_valid", nfc_cmd_valid, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_rdata0", r0_cmd_rdata, 8'h00);
        chk("rst_rdata1", r1_cmd_rdata, 8'h00);
        chk("rst_addr", nfc_cmd_addr, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // single r0 read with a slow downstream
        fix[0] = 1; fw[0] = 0; fa[0] = 6'h04; fd[0] = 8'h00;
        nfc_cmd_ready = 1; req_cnt[0] = 1;
        wait_sig(0, "t1_ready0");
        chk("t1_ready1", r1_cmd_ready, 0);
        @(negedge clk);
        chk("t1_valid", nfc_cmd_valid, 1);
        chk("t1_addr", nfc_cmd_addr, 6'h04);
        chk("t1_write", nfc_cmd_write, 0);
        chk("t1_ready_pulse", r0_cmd_ready, 0);
        @(negedge clk);
        chk("t1_valid_drop", nfc_cmd_valid, 0);
        repeat (18) @(posedge clk);
        #2 nfc_cmd_done = 1; nfc_cmd_rdata = 8'h3C;
        @(posedge clk); #2 nfc_cmd_done = 0; nfc_cmd_rdata = 8'h00;
        @(negedge clk);
        chk("t1_done0", r0_cmd_done, 1);
        chk("t1_rdata0", r0_cmd_rdata, 8'h3C);
        chk("t1_done1", r1_cmd_done, 0);
        chk("t1_rdata1", r1_cmd_rdata, 8'h00);
        @(negedge clk);
        chk("t1_idle", arb_busy, 0);
        chk("t1_hold", r0_cmd_rdata, 8'h3C);

        // simultaneous requests alternate starting with r0
        do_reset();
        dev_auto = 1; req_cnt[0] = 2; req_cnt[1] = 2;
        wait_gq(4, "t2_grants");
        chk("t2_g0", gqa(0), 0);
        chk("t2_g1", gqa(1), 1);
        chk("t2_g2", gqa(2), 0);
        chk("t2_g3", gqa(3), 1);
        wait_idle("t2_idle");

        // lock keeps r0 out until it drops
        do_reset();
        dev_auto = 1; r1_lock = 1; req_cnt[0] = 1; req_cnt[1] = 4;
        wait_gq(3, "t3_locked");
        @(posedge clk); #2 r1_lock = 0;
        wait_gq(5, "t3_grants");
        chk("t3_g0", gqa(0), 1);
        chk("t3_g1", gqa(1), 1);
        chk("t3_g2", gqa(2), 1);
        chk("t3_g3", gqa(3), 0);
        chk("t3_g4", gqa(4), 1);
        wait_idle("t3_idle");

        // r1 write blocks a later r0 until it completes
        do_reset();
        dev_auto = 0; nfc_cmd_ready = 1;
        fix[1] = 1; fw[1] = 1; fa[1] = 6'h01; fd[1] = 8'h0C; req_cnt[1] = 1;
        @(posedge clk); #2 req_cnt[0] = 1;
        wait_sig(1, "t4_ready1");
        @(negedge clk);
        chk("t4_write", nfc_cmd_write, 1);
        chk("t4_addr", nfc_cmd_addr, 6'h01);
        chk("t4_wdata", nfc_cmd_wdata, 8'h0C);
        chk("t4_r0_wait_a", r0_cmd_ready, 0);
        @(posedge clk); #2 nfc_cmd_done = 1; nfc_cmd_rdata = 8'h5A;
        @(negedge clk);
        chk("t4_r0_wait_b", r0_cmd_ready, 0);
        @(posedge clk); #2 nfc_cmd_done = 0;
        @(negedge clk);
        chk("t4_done1", r1_cmd_done, 1);
        chk("t4_rdata1", r1_cmd_rdata, 8'h5A);
        chk("t4_r0_wait_c", r0_cmd_ready, 0);
        @(negedge clk);
        chk("t4_ready0", r0_cmd_ready, 1);
        dev_auto = 1;
        wait_idle("t4_idle");

`ifdef NFC_ARB_TIMEOUT_EN
        // downstream never completes: abort after the watchdog runs out
        do_reset();
        dev_auto = 0; nfc_cmd_ready = 1; nfc_cmd_done = 0;
        req_cnt[0] = 1;
        wait_sig(0, "t5_ready0");
        @(negedge clk);
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!r0_cmd_done && k < 100);
            chk("t5_cycles", k, 18);
        end
        chk("t5_rdata0", r0_cmd_rdata, 8'hFF);
        chk("t5_err", timeout_err, 1);
        @(negedge clk);
        chk("t5_idle", arb_busy, 0);
        chk("t5_err_pulse", timeout_err, 0);
`endif

        // asynchronous reset while waiting for completion
        do_reset();
        dev_auto = 0; nfc_cmd_ready = 1; nfc_cmd_done = 0;
        fix[1] = 1; fw[1] = 1; fa[1] = 6'h3F; fd[1] = 8'hAA; req_cnt[1] = 1;
        wait_sig(1, "t6_ready1");
        repeat (3) @(negedge clk);
        chk("t6_waiting", arb_busy, 1);
        #2 rst_n = 1'b0;
        clear_reqs();
        #1;
        chk("t6_busy", arb_busy, 0);
        chk("t6_grant", grant_id, 0);
        chk("t6_write", nfc_cmd_write, 0);
        chk("t6_addr", nfc_cmd_addr, 0);
        chk("t6_wdata", nfc_cmd_wdata, 0);
        chk("t6_valid", nfc_cmd_valid, 0);
        chk("t6_done1", r1_cmd_done, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        req_cnt[1] = 1;
        wait_sig(1, "t6_reaccept");
        dev_auto = 1;
        wait_sig(3, "t6_redone");
        wait_idle("t6_idle");

        // randomized traffic with lock toggling
        do_reset();
        dev_auto = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            for (int n = 0; n < 2; n++)
                if (req_cnt[n] == 0 && $urandom_range(0, 3) == 0)
                    req_cnt[n] = $urandom_range(1, 3);
            if ($urandom_range(0, 19) == 0) r1_lock = !r1_lock;
        end
        @(posedge clk); #2 r1_lock = 0;
        wait_idle("rand_idle");
        chk("rand_progress", gq.size() > 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
